// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM states, grant encodings,
// default timeouts and the timer width helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_ECHO = 2'b01;
    localparam logic [1:0] GNT_MSG  = 2'b10;

    localparam int DEF_DATA_W        = 8;
    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_LOCK_TIMEOUT  = 1024;

    function automatic int timer_w(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle seen by the arbiter.
// master = arbiter side, slave = requester/transmitter side.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              echo_valid;
    logic [DATA_W-1:0] echo_data;
    logic              echo_ready;
    logic              msg_valid;
    logic [DATA_W-1:0] msg_data;
    logic              msg_last;
    logic              msg_ready;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;

    modport master (
        input  echo_valid, echo_data, msg_valid, msg_data, msg_last, tx_busy,
        output echo_ready, msg_ready, tx_start, tx_data
    );

    modport slave (
        output echo_valid, echo_data, msg_valid, msg_data, msg_last, tx_busy,
        input  echo_ready, msg_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_arb_timer.sv
// Loadable down-counter; expire is high in the enabled cycle that takes the count
// from 1 to 0, i.e. after exactly load_val consecutive enabled cycles.
module uart_tx_arbiter_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign expire = en && !load && (count_q == W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between the echo and message requesters.
// Optional MSG_LOCK_TIMEOUT_EN drops a stalled message lock after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SW,
    uart_tx_arbiter_if.master      bus,
    output logic [1:0]             grant,
    output logic                   locked,
    output logic                   start_err
);
    // Both timers share one load width so either timeout can be reconfigured freely.
    localparam int TimerW = timer_w((START_TIMEOUT > LOCK_TIMEOUT) ? START_TIMEOUT : LOCK_TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              locked_q, locked_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              echo_ready_q, echo_ready_d;
    logic              msg_ready_q, msg_ready_d;
    logic              start_err_q, start_err_d;

    logic              owner_is_msg;
    logic              owner_valid;
    logic              start_expire;
    logic              lock_expire;

    assign owner_is_msg = (grant_q == GNT_MSG);
    assign owner_valid  = owner_is_msg ? bus.msg_valid : bus.echo_valid;

    uart_tx_arbiter_arb_timer #(
        .W (TimerW)
    ) u_start_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == LOAD),
        .load_val (TimerW'(START_TIMEOUT)),
        .en       ((state_q == WAIT_BUSY) && !bus.tx_busy),
        .expire   (start_expire)
    );

`ifdef MSG_LOCK_TIMEOUT_EN
    logic lock_run;
    // Any cycle outside the idle-and-starving condition (incl. an accept) reloads the timer.
    assign lock_run = locked_q && (state_q == IDLE) && !bus.msg_valid;

    uart_tx_arbiter_arb_timer #(
        .W (TimerW)
    ) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (!lock_run),
        .load_val (TimerW'(LOCK_TIMEOUT)),
        .en       (lock_run),
        .expire   (lock_expire)
    );
`else
    assign lock_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        locked_d     = locked_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        echo_ready_d = 1'b0;
        msg_ready_d  = 1'b0;
        start_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (lock_expire) begin
                    locked_d = 1'b0;
                end
                if (!bus.tx_busy) begin
                    if (bus.msg_valid && (locked_q || SW || !bus.echo_valid)) begin
                        grant_d = GNT_MSG;
                        state_d = LOAD;
                    end else if (bus.echo_valid && !locked_q) begin
                        grant_d = GNT_ECHO;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (owner_valid) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_BUSY;
                    if (owner_is_msg) begin
                        msg_ready_d = 1'b1;
                        tx_data_d   = bus.msg_data;
                        locked_d    = !bus.msg_last;
                    end else begin
                        echo_ready_d = 1'b1;
                        tx_data_d    = bus.echo_data;
                    end
                end else begin
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (start_expire) begin
                    start_err_d = 1'b1;
                    grant_d     = GNT_NONE;
                    state_d     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            locked_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            echo_ready_q <= 1'b0;
            msg_ready_q  <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            locked_q     <= locked_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            echo_ready_q <= echo_ready_d;
            msg_ready_q  <= msg_ready_d;
            start_err_q  <= start_err_d;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.echo_ready = echo_ready_q;
    assign bus.msg_ready  = msg_ready_q;
    assign grant          = grant_q;
    assign locked         = locked_q;
    assign start_err      = start_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: random byte rounds predicted by
// transaction-order rules, with a scoreboard monitor on every tx_start.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] gnt;
        logic       lck;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw;
    logic [1:0] grant;
    logic       locked;
    logic       start_err;

    int         checks = 0;
    int         errors = 0;
    int         txn_n  = 0;
    bit         tx_stuck = 1'b0;
    int         frame_len = 8;
    exp_t       sb_q[$];
    logic [7:0] echo_src[$];
    logic [7:0] msg_src[$];

    uart_tx_arbiter_if #(.DATA_W(8)) bus();

    uart_tx_arbiter #(
        .DATA_W        (8),
        .START_TIMEOUT (16),
        .LOCK_TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (sw),
        .bus       (bus),
        .grant     (grant),
        .locked    (locked),
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [7:0] d, input logic [1:0] g, input logic l);
        exp_t e;
        e.data = d;
        e.gnt  = g;
        e.lck  = l;
        sb_q.push_back(e);
    endfunction

    // Reference order: with both requesters waiting, SW decides who goes first; a
    // started message is atomic, and a requester that keeps presenting keeps winning.
    function automatic void model_push(input bit sw_val);
        bit msg_first;
        msg_first = (msg_src.size() > 0) && (sw_val || (echo_src.size() == 0));
        if (msg_first) begin
            foreach (msg_src[i]) push_exp(msg_src[i], GNT_MSG, i != msg_src.size() - 1);
            foreach (echo_src[i]) push_exp(echo_src[i], GNT_ECHO, 1'b0);
        end else begin
            foreach (echo_src[i]) push_exp(echo_src[i], GNT_ECHO, 1'b0);
            foreach (msg_src[i]) push_exp(msg_src[i], GNT_MSG, i != msg_src.size() - 1);
        end
    endfunction

    // Transmitter model: busy for frame_len cycles after each launch unless stuck.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_start === 1'b1 && !tx_stuck) begin
                bus.tx_busy = 1'b1;
                repeat (frame_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                txn_n++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got launch of %02h grant %b, required no launch",
                             bus.tx_data, grant);
                end else begin
                    e = sb_q.pop_front();
                    check("tx_data", int'(bus.tx_data), int'(e.data));
                    check("grant", int'(grant), int'(e.gnt));
                    check("locked", int'(locked), int'(e.lck));
                    check("ready_pulse", int'({bus.echo_ready, bus.msg_ready}),
                          int'({e.gnt == GNT_ECHO, e.gnt == GNT_MSG}));
                    $display("txn %0d: byte %02h owner %b locked %b", txn_n, bus.tx_data, grant, locked);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input bit is_msg, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if ((is_msg ? bus.msg_ready : bus.echo_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready for %s, required ready", is_msg ? "msg" : "echo");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if (grant == GNT_NONE && bus.tx_busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got grant %b busy %b, required idle", grant, bus.tx_busy);
        end
    endtask

    task automatic run_echo();
        bit ok;
        while (echo_src.size() > 0) begin
            bus.echo_data  = echo_src[0];
            bus.echo_valid = 1'b1;
            wait_ready(1'b0, ok);
            void'(echo_src.pop_front());
            if (!ok) echo_src.delete();
        end
        bus.echo_valid = 1'b0;
    endtask

    task automatic run_msg();
        bit ok;
        while (msg_src.size() > 0) begin
            bus.msg_data  = msg_src[0];
            bus.msg_last  = (msg_src.size() == 1);
            bus.msg_valid = 1'b1;
            wait_ready(1'b1, ok);
            void'(msg_src.pop_front());
            if (!ok) msg_src.delete();
        end
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    task automatic run_round(input bit sw_val);
        wait_idle();
        sw = sw_val;
        model_push(sw_val);
        fork
            run_echo();
            run_msg();
        join
    endtask

    initial begin
        int lat;
        int cnt;
        bit ok;

        rst = 1'b1;
        sw  = 1'b0;
        bus.echo_valid = 1'b0;
        bus.echo_data  = '0;
        bus.msg_valid  = 1'b0;
        bus.msg_data   = '0;
        bus.msg_last   = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_outputs", int'({grant, locked, start_err, bus.tx_start, bus.echo_ready, bus.msg_ready}), 0);
        check("reset_tx_data", int'(bus.tx_data), 0);

        // Single echo byte: launch latency and grant lifetime.
        wait_idle();
        frame_len = 20;
        push_exp(8'h41, GNT_ECHO, 1'b0);
        bus.echo_data  = 8'h41;
        bus.echo_valid = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #2;
            if (bus.tx_start === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.echo_valid = 1'b0;
        check("start_latency", lat, 2);
        check("latency_echo_ready", int'(bus.echo_ready), 1);
        repeat (5) @(posedge clk);
        #2;
        check("grant_while_busy", int'(grant), int'(GNT_ECHO));
        for (int i = 0; i < 100 && bus.tx_busy; i++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #2;
        check("grant_released", int'(grant), int'(GNT_NONE));
        check("tx_data_held", int'(bus.tx_data), 'h41);

        // Valid withdrawn during LOAD: no launch, grant cleared.
        wait_idle();
        bus.echo_data  = 8'h77;
        bus.echo_valid = 1'b1;
        @(posedge clk);
        #2 bus.echo_valid = 1'b0;
        check("load_grant", int'(grant), int'(GNT_ECHO));
        @(posedge clk);
        #2;
        check("drop_no_start", int'({grant, bus.tx_start, bus.echo_ready}), 0);
        repeat (4) @(posedge clk);

        // Contention both ways, then "HI" with echo held behind the lock.
        frame_len = 6;
        echo_src = '{8'h31};
        msg_src  = '{8'h48};
        run_round(1'b0);
        echo_src = '{8'h31};
        msg_src  = '{8'h48};
        run_round(1'b1);
        echo_src = '{8'h45};
        msg_src  = '{8'h48, 8'h49};
        run_round(1'b1);
        echo_src = '{8'h61, 8'h62};
        msg_src  = '{8'h48, 8'h49};
        run_round(1'b0);

        for (int r = 0; r < 20; r++) begin
            int n_e;
            int n_m;
            frame_len = $urandom_range(3, 12);
            n_e = $urandom_range(0, 3);
            n_m = $urandom_range(0, 3);
            for (int k = 0; k < n_e; k++) echo_src.push_back(8'($urandom));
            for (int k = 0; k < n_m; k++) msg_src.push_back(8'($urandom));
            run_round(1'($urandom_range(0, 1)));
        end

        // Transmitter never goes busy: start_err after START_TIMEOUT cycles.
        wait_idle();
        tx_stuck = 1'b1;
        push_exp(8'h5A, GNT_ECHO, 1'b0);
        bus.echo_data  = 8'h5A;
        bus.echo_valid = 1'b1;
        wait_ready(1'b0, ok);
        bus.echo_valid = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (start_err === 1'b1) begin
                cnt = i;
                break;
            end
        end
        check("start_err_delay", cnt, 16);
        check("start_err_grant", int'(grant), int'(GNT_NONE));
        @(posedge clk);
        #2;
        check("start_err_single", int'(start_err), 0);
        tx_stuck = 1'b0;
        echo_src = '{8'h3C};
        run_round(1'b1);

`ifdef MSG_LOCK_TIMEOUT_EN
        // Stalled message: lock drops after LOCK_TIMEOUT idle cycles and echo proceeds.
        wait_idle();
        push_exp(8'hA1, GNT_MSG, 1'b1);
        bus.msg_data  = 8'hA1;
        bus.msg_last  = 1'b0;
        bus.msg_valid = 1'b1;
        wait_ready(1'b1, ok);
        bus.msg_valid = 1'b0;
        push_exp(8'h55, GNT_ECHO, 1'b0);
        bus.echo_data  = 8'h55;
        bus.echo_valid = 1'b1;
        wait_ready(1'b0, ok);
        bus.echo_valid = 1'b0;
`endif

        // Reset while locked and waiting for the frame to finish.
        wait_idle();
        frame_len = 30;
        push_exp(8'h48, GNT_MSG, 1'b1);
        bus.msg_data  = 8'h48;
        bus.msg_last  = 1'b0;
        bus.msg_valid = 1'b1;
        wait_ready(1'b1, ok);
        bus.msg_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("locked_before_reset", int'(locked), 1);
        check("grant_before_reset", int'(grant), int'(GNT_MSG));
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("post_reset_outputs", int'({grant, locked, start_err, bus.tx_start, bus.echo_ready, bus.msg_ready}), 0);
        frame_len = 5;
        echo_src = '{8'hE5};
        run_round(1'b1);

        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("scoreboard_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
